// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Optional feature macro used by the top: DMEM_ARB_PERF_EN.
package dmem_arb_pkg;

  typedef enum logic {
    S_CORE  = 1'b0,
    S_FORCE = 1'b1
  } arb_state_e;

  // Debug accesses are always full-word.
  localparam logic [3:0] DBG_BE_FULL = 4'hF;

  // Low byte-address bits that must be zero for a word-aligned access.
  localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

  // Returns 1 when a debug byte address is misaligned or beyond the dmem depth.
  function automatic logic dbg_addr_bad(input logic [31:0] addr, input int unsigned addr_w);
    logic [31:0] hi_mask;
    hi_mask = 32'hFFFF_FFFF << (addr_w + 2);
    return ((addr & hi_mask) != 32'd0) || ((addr & WORD_ALIGN_MASK) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the core MEM stage, the debug/loader port and dmem.
// The slave modport is the arbiter's view; master is the surrounding system.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 8
) ();
  logic              core_req;
  logic              core_we;
  logic [3:0]        core_be;
  logic [31:0]       core_addr;
  logic [31:0]       core_wdata;
  logic [31:0]       core_rdata;
  logic              core_stall;

  logic              dbg_req;
  logic              dbg_we;
  logic [31:0]       dbg_addr;
  logic [31:0]       dbg_wdata;
  logic              dbg_gnt;
  logic              dbg_rvalid;
  logic [31:0]       dbg_rdata;
  logic              dbg_err;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  core_req, core_we, core_be, core_addr, core_wdata,
    output core_rdata, core_stall,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_be, core_addr, core_wdata,
    input  core_rdata, core_stall,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata, dbg_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/dmem_arb_starve_cnt.sv
// Counts consecutive cycles a debug request is blocked by the core and
// raises force_req on the cycle the limit is reached.
module dmem_arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_core,
  input  logic core_req,
  input  logic dbg_req,
  input  logic dbg_gnt,
  output logic force_req
);

  logic [3:0] wait_cnt;

  // Force when the block reaches MAX_WAIT cycles including this one.
  assign force_req = in_core && core_req && dbg_req && (wait_cnt == 4'(MAX_WAIT - 1));

  // Wait counter: grows only while dbg is blocked by the core, clears otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= 4'd0;
    end else if (!in_core || !dbg_req || dbg_gnt || force_req) begin
      wait_cnt <= 4'd0;
    end else if (core_req) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter sharing single-port dmem between the core MEM stage (fixed
// priority) and a debug/loader port, with a starvation-forced core stall.
// Optional macro DMEM_ARB_PERF_EN adds saturating perf counters.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  dmem_arbiter_if.slave bus
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0] perf_stall_cnt,
  output logic [15:0] perf_dbg_cnt
`endif
);

  arb_state_e state, state_nxt;
  logic       force_req;
  logic       dbg_gnt_c;
  logic       core_acc;
  logic       dbg_bad;
  logic       dbg_rd_ok;
  logic       core_addr_unused;

  // Core addresses are deliberately truncated; the dropped bits are not checked.
  assign core_addr_unused = ^{bus.core_addr[31:ADDR_W+2], bus.core_addr[1:0]};

  assign dbg_bad    = dbg_addr_bad(bus.dbg_addr, ADDR_W);
  assign dbg_rd_ok  = dbg_gnt_c && !bus.dbg_we && !dbg_bad;

  assign bus.dbg_gnt    = dbg_gnt_c;
  assign bus.dbg_err    = dbg_gnt_c && dbg_bad;
  assign bus.core_stall = (state == S_FORCE);
  assign bus.core_rdata = bus.mem_rdata;

  dmem_arb_starve_cnt #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_core  (state == S_CORE),
    .core_req (bus.core_req),
    .dbg_req  (bus.dbg_req),
    .dbg_gnt  (dbg_gnt_c),
    .force_req(force_req)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_CORE;
    else        state <= state_nxt;
  end

  // Next state, grant decision and memory-port mux.
  always_comb begin
    state_nxt     = state;
    dbg_gnt_c     = 1'b0;
    core_acc      = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'h0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    case (state)
      S_CORE: begin
        if (bus.core_req)     core_acc  = 1'b1;
        else if (bus.dbg_req) dbg_gnt_c = 1'b1;
        if (force_req)        state_nxt = S_FORCE;
      end
      S_FORCE: begin
        dbg_gnt_c = bus.dbg_req;
        state_nxt = S_CORE;
      end
      default: state_nxt = S_CORE;
    endcase
    if (core_acc) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.core_we;
      bus.mem_be    = bus.core_be;
      bus.mem_addr  = bus.core_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.core_wdata;
    end else if (dbg_gnt_c && !dbg_bad) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.dbg_we;
      bus.mem_be    = DBG_BE_FULL;
      bus.mem_addr  = bus.dbg_addr[ADDR_W+1:2];
      bus.mem_wdata = bus.dbg_wdata;
    end
  end

  // Debug read return: capture at the edge ending the grant cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.dbg_rvalid <= 1'b0;
      bus.dbg_rdata  <= 32'd0;
    end else begin
      bus.dbg_rvalid <= dbg_rd_ok;
      if (dbg_rd_ok) bus.dbg_rdata <= bus.mem_rdata;
    end
  end

`ifdef DMEM_ARB_PERF_EN
  // Saturating counts of forced stall cycles and debug grants (errors included).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_cnt <= 16'd0;
      perf_dbg_cnt   <= 16'd0;
    end else begin
      if (state == S_FORCE && perf_stall_cnt != 16'hFFFF) perf_stall_cnt <= perf_stall_cnt + 16'd1;
      if (dbg_gnt_c && perf_dbg_cnt != 16'hFFFF)          perf_dbg_cnt   <= perf_dbg_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter (ADDR_W = 8, MAX_WAIT = 4).
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  logic [31:0] ram [256];

  dmem_arbiter_if #(.ADDR_W(8)) bus ();

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_dbg_cnt;
`endif

  dmem_arbiter #(.ADDR_W(8), .MAX_WAIT(4)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
`ifdef DMEM_ARB_PERF_EN
    ,
    .perf_stall_cnt(perf_stall_cnt),
    .perf_dbg_cnt  (perf_dbg_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational read, byte-enabled write at the clock edge.
  assign bus.mem_rdata = ram[bus.mem_addr];
  always @(posedge clk) begin
    if (bus.mem_en && bus.mem_we) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) ram[bus.mem_addr][b*8 +: 8] <= bus.mem_wdata[b*8 +: 8];
    end
  end

  typedef struct {
    logic        core_req;
    logic        core_we;
    logic [3:0]  core_be;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        chk_rd;
    logic [31:0] exp_rdata;
    logic        exp_en;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [7:0]  exp_addr;
    logic        exp_gnt;
    logic        exp_err;
    logic        exp_stall;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_idle();
    bus.core_req   = 1'b0;
    bus.core_we    = 1'b0;
    bus.core_be    = 4'h0;
    bus.core_addr  = 32'd0;
    bus.core_wdata = 32'd0;
    bus.dbg_req    = 1'b0;
    bus.dbg_we     = 1'b0;
    bus.dbg_addr   = 32'd0;
    bus.dbg_wdata  = 32'd0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    bus.dbg_req   = 1'b1;
    bus.dbg_we    = we;
    bus.dbg_addr  = addr;
    bus.dbg_wdata = wdata;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

`ifdef DMEM_ARB_PERF_EN
  task automatic forced_grant();
    logic seen;
    seen = 1'b0;
    bus.core_req = 1'b1;
    bus.core_we  = 1'b0;
    dbg_drive(1'b1, 32'h40, 32'h9);
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = bus.dbg_gnt;
      next_cycle();
    end
    check("perf_forced_gnt_seen", {63'd0, seen}, 64'd1);
    set_idle();
    next_cycle();
  endtask
`endif

  int   gnt_cyc;
  int   stall_cyc;
  int   stall_n;
  logic rv_seen;
  logic found;

  initial begin
    tests  = 0;
    failed = 0;
    rst_n  = 1'b0;
    set_idle();

    //            creq cwe cbe   caddr          cwdata         dreq dwe daddr          dwdata    chk exp_rdata      en we be    addr   gnt err stl
    vecs[0]  = '{1'b1,1'b1,4'hF,32'h0000_0008,32'hDEAD_BEEF,1'b0,1'b0,32'h0,        32'h0,    1'b0,32'h0,        1'b1,1'b1,4'hF,8'd2,  1'b0,1'b0,1'b0};
    vecs[1]  = '{1'b1,1'b0,4'h0,32'h0000_0008,32'h0,        1'b0,1'b0,32'h0,        32'h0,    1'b1,32'hDEAD_BEEF,1'b1,1'b0,4'h0,8'd2,  1'b0,1'b0,1'b0};
    vecs[2]  = '{1'b1,1'b1,4'hF,32'h0000_000C,32'h1,        1'b0,1'b0,32'h0,        32'h0,    1'b0,32'h0,        1'b1,1'b1,4'hF,8'd3,  1'b0,1'b0,1'b0};
    vecs[3]  = '{1'b1,1'b1,4'h3,32'h0000_01FC,32'hA5A5_A5A5,1'b0,1'b0,32'h0,        32'h0,    1'b0,32'h0,        1'b1,1'b1,4'h3,8'd127,1'b0,1'b0,1'b0};
    vecs[4]  = '{1'b1,1'b0,4'h0,32'h0000_0010,32'h0,        1'b1,1'b0,32'h20,       32'h0,    1'b0,32'h0,        1'b1,1'b0,4'h0,8'd4,  1'b0,1'b0,1'b0};
    vecs[5]  = '{1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b1,1'b0,32'h0C,       32'h0,    1'b0,32'h0,        1'b1,1'b0,4'hF,8'd3,  1'b1,1'b0,1'b0};
    vecs[6]  = '{1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b1,1'b1,32'h3FC,      32'h77,   1'b0,32'h0,        1'b1,1'b1,4'hF,8'd255,1'b1,1'b0,1'b0};
    vecs[7]  = '{1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b1,1'b0,32'h02,       32'h0,    1'b0,32'h0,        1'b0,1'b0,4'h0,8'd0,  1'b1,1'b1,1'b0};
    vecs[8]  = '{1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b1,1'b0,32'h400,      32'h0,    1'b0,32'h0,        1'b0,1'b0,4'h0,8'd0,  1'b1,1'b1,1'b0};
    vecs[9]  = '{1'b0,1'b0,4'h0,32'h0,        32'h0,        1'b0,1'b0,32'h0,        32'h0,    1'b0,32'h0,        1'b0,1'b0,4'h0,8'd0,  1'b0,1'b0,1'b0};
    vecs[10] = '{1'b1,1'b0,4'h0,32'hFFFF_0008,32'h0,        1'b0,1'b0,32'h0,        32'h0,    1'b1,32'hDEAD_BEEF,1'b1,1'b0,4'h0,8'd2,  1'b0,1'b0,1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs",
          {58'd0, bus.core_stall, bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_err, bus.mem_en, bus.mem_we},
          64'd0);
    check("reset_dbg_rdata", {32'd0, bus.dbg_rdata}, 64'd0);
    next_cycle();
    rst_n = 1'b1;
    next_cycle();

    // Single-cycle vectors, each followed by an idle cycle so the wait counter restarts.
    for (int i = 0; i < 11; i++) begin
      bus.core_req   = vecs[i].core_req;
      bus.core_we    = vecs[i].core_we;
      bus.core_be    = vecs[i].core_be;
      bus.core_addr  = vecs[i].core_addr;
      bus.core_wdata = vecs[i].core_wdata;
      bus.dbg_req    = vecs[i].dbg_req;
      bus.dbg_we     = vecs[i].dbg_we;
      bus.dbg_addr   = vecs[i].dbg_addr;
      bus.dbg_wdata  = vecs[i].dbg_wdata;
      @(negedge clk);
      check($sformatf("vec%0d_ctrl", i),
            {60'd0, bus.mem_en, bus.dbg_gnt, bus.dbg_err, bus.core_stall},
            {60'd0, vecs[i].exp_en, vecs[i].exp_gnt, vecs[i].exp_err, vecs[i].exp_stall});
      if (vecs[i].exp_en)
        check($sformatf("vec%0d_mem", i),
              {51'd0, bus.mem_we, bus.mem_be, bus.mem_addr},
              {51'd0, vecs[i].exp_we, vecs[i].exp_be, vecs[i].exp_addr});
      if (vecs[i].chk_rd)
        check($sformatf("vec%0d_core_rdata", i), {32'd0, bus.core_rdata}, {32'd0, vecs[i].exp_rdata});
      next_cycle();
      set_idle();
      next_cycle();
    end

    // Starvation: core holds the memory, dbg write of 5 to 0x28 must be forced in.
    bus.core_req  = 1'b1;
    bus.core_addr = 32'h0;
    dbg_drive(1'b1, 32'h28, 32'h5);
    gnt_cyc   = -1;
    stall_cyc = -1;
    stall_n   = 0;
    rv_seen   = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.core_stall) begin
        stall_n++;
        stall_cyc = c;
      end
      if (bus.dbg_rvalid) rv_seen = 1'b1;
      if (bus.dbg_gnt && gnt_cyc < 0) gnt_cyc = c;
      next_cycle();
      if (gnt_cyc >= 0) bus.dbg_req = 1'b0;
    end
    check("starve_gnt_cycle", 64'(gnt_cyc), 64'd4);
    check("starve_stall_count", 64'(stall_n), 64'd1);
    check("starve_stall_cycle", 64'(stall_cyc), 64'd4);
    check("starve_no_rvalid_on_write", {63'd0, rv_seen}, 64'd0);
    check("starve_ram10", {32'd0, ram[10]}, 64'd5);
    set_idle();
    next_cycle();

    // Back-to-back debug reads: rvalid of the first coincides with the second grant.
    dbg_drive(1'b0, 32'h0C, 32'h0);
    @(negedge clk);
    check("b2b_first_gnt", {63'd0, bus.dbg_gnt}, 64'd1);
    next_cycle();
    bus.dbg_addr = 32'h28;
    @(negedge clk);
    check("b2b_second", {30'd0, bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_rdata}, {30'd0, 1'b1, 1'b1, 32'd1});
    next_cycle();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    check("b2b_second_data", {30'd0, bus.dbg_gnt, bus.dbg_rvalid, bus.dbg_rdata}, {30'd0, 1'b0, 1'b1, 32'd5});
    next_cycle();
    @(negedge clk);
    check("b2b_rvalid_drops", {63'd0, bus.dbg_rvalid}, 64'd0);
    next_cycle();

    // Misaligned and out-of-range debug read.
    dbg_drive(1'b0, 32'h401, 32'h0);
    @(negedge clk);
    check("err_pulse", {61'd0, bus.dbg_gnt, bus.dbg_err, bus.mem_en}, {61'd0, 3'b110});
    next_cycle();
    set_idle();
    @(negedge clk);
    check("err_no_rvalid", {61'd0, bus.dbg_rvalid, bus.dbg_err, bus.dbg_gnt}, 64'd0);
    next_cycle();

    // Reset asserted while in S_FORCE, dbg_req held through reset.
    bus.core_req = 1'b1;
    dbg_drive(1'b0, 32'h0C, 32'h0);
    found = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clk);
      if (bus.core_stall) found = 1'b1;
      else next_cycle();
    end
    check("rst_force_reached", {63'd0, found}, 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_force", {61'd0, bus.core_stall, bus.dbg_gnt, bus.dbg_rvalid}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus.core_req = 1'b0;
    #1;
    check("rst_regrant", {62'd0, bus.dbg_gnt, bus.dbg_err}, {62'd0, 2'b10});
    next_cycle();
    bus.dbg_req = 1'b0;
    @(negedge clk);
    check("rst_regrant_data", {31'd0, bus.dbg_rvalid, bus.dbg_rdata}, {31'd0, 1'b1, 32'd1});
    next_cycle();

`ifdef DMEM_ARB_PERF_EN
    // Perf counters: 3 forced grants and 2 idle-cycle grants.
    set_idle();
    do_reset();
    forced_grant();
    forced_grant();
    forced_grant();
    for (int k = 0; k < 2; k++) begin
      dbg_drive(1'b0, 32'h0C, 32'h0);
      next_cycle();
      set_idle();
      next_cycle();
    end
    @(negedge clk);
    check("perf_stall_cnt", {48'd0, perf_stall_cnt}, 64'd3);
    check("perf_dbg_cnt", {48'd0, perf_dbg_cnt}, 64'd5);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
